// File: rtl/prism_cfg_sequencer.sv
// prism_cfg_sequencer
// Buffers 64-bit configuration words written by the host and replays each one
// into the latch-chain loader as a low-half/high-half write pair, then waits for
// the loader's shift to finish. A reload request re-applies the last committed word.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   host_wr/addr/wdata host write port (0x8 lo stage, 0xC push, 0x10 control)
//   reload_req        one-cycle request to replay the last committed word
//   ld_write_req/address/data  write strobe, address and data to the loader
//   ld_busy           loader busy
//   busy              sequencer has work in flight or queued
//   fifo_level        buffered entry count
//   overflow          sticky: a push was dropped on a full FIFO
//   last_valid        a word has been committed since reset
//   done              one-cycle pulse when a load completes
module prism_cfg_sequencer #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned LVL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_wr,
  input  logic [5:0]       host_addr,
  input  logic [31:0]      host_wdata,
  input  logic             reload_req,
  output logic             ld_write_req,
  output logic [5:0]       ld_address,
  output logic [31:0]      ld_data,
  input  logic             ld_busy,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             last_valid,
  output logic             done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSendLo, StSendHi, StWaitBusy, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       lo_stage_q;
  logic [63:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [63:0]       work_q, work_d;
  logic [63:0]       last_cfg_q;
  logic              last_valid_q;
  logic              overflow_q, overflow_d;
  logic              reload_pend_q, reload_pend_d;

  logic wr_lo, wr_push, wr_ctl;
  logic fifo_full, fifo_empty, push_ok, push_drop;
  logic pop, take_reload, commit, reload_set;

  assign wr_lo   = host_wr && (host_addr == 6'h08);
  assign wr_push = host_wr && (host_addr == 6'h0C);
  assign wr_ctl  = host_wr && (host_addr == 6'h10);

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  // A push on a full FIFO is dropped even if a pop happens on the same edge.
  assign push_ok    = wr_push && !fifo_full;
  assign push_drop  = wr_push && fifo_full;

  assign reload_set = reload_req || (wr_ctl && host_wdata[1]);

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    take_reload  = 1'b0;
    commit       = 1'b0;
    done         = 1'b0;
    ld_write_req = 1'b0;
    ld_address   = 6'h00;
    ld_data      = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StSendLo;
        end else if (reload_pend_q) begin
          take_reload = 1'b1;
          state_d     = StSendLo;
        end
      end
      StSendLo: begin
        ld_write_req = 1'b1;
        ld_address   = 6'h08;
        ld_data      = work_q[31:0];
        state_d      = StSendHi;
      end
      StSendHi: begin
        ld_write_req = 1'b1;
        ld_address   = 6'h0C;
        ld_data      = work_q[63:32];
        state_d      = StWaitBusy;
      end
      StWaitBusy: begin
        if (ld_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!ld_busy) begin
          done    = 1'b1;
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    work_d = work_q;
    if (pop)              work_d = mem_q[rd_ptr_q];
    else if (take_reload) work_d = last_cfg_q;

    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);

    overflow_d = overflow_q;
    if (push_drop)                     overflow_d = 1'b1;
    else if (wr_ctl && host_wdata[0])  overflow_d = 1'b0;

    // Requests arriving while one is pending, or on the cycle it is taken, merge.
    reload_pend_d = reload_pend_q;
    if (take_reload)                     reload_pend_d = 1'b0;
    else if (reload_set && last_valid_q) reload_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      lo_stage_q    <= 32'h0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      work_q        <= 64'h0;
      last_cfg_q    <= 64'h0;
      last_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      reload_pend_q <= reload_pend_d;
      if (wr_lo)   lo_stage_q <= host_wdata;
      if (push_ok) wr_ptr_q   <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q   <= rd_ptr_q + PtrW'(1);
      if (commit) begin
        last_cfg_q   <= work_q;
        last_valid_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {host_wdata, lo_stage_q};
  end

  assign busy       = (state_q != StIdle) || !fifo_empty || reload_pend_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign last_valid = last_valid_q;

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Bench for prism_cfg_sequencer: transaction-level model (word queue, pending
// reload flag, load timeline) plus a simple loader model driving ld_busy.
module tb_prism_cfg_sequencer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        reload_req = 1'b0;
  logic        ld_write_req;
  logic [5:0]  ld_address;
  logic [31:0] ld_data;
  logic        ld_busy = 1'b0;
  logic        busy;
  logic [1:0]  fifo_level;
  logic        overflow;
  logic        last_valid;
  logic        done;

  always #5 clk = ~clk;

  prism_cfg_sequencer #(.FIFO_DEPTH(DEPTH), .LVL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .reload_req(reload_req), .ld_write_req(ld_write_req),
    .ld_address(ld_address), .ld_data(ld_data), .ld_busy(ld_busy), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow), .last_valid(last_valid), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [5:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];
  int  dlog[$];

  // Model state: queued words, staging, committed word, and the load in flight.
  logic [63:0] m_q[$];
  logic [31:0] m_lo;
  logic [63:0] m_last, m_work;
  bit m_lv, m_ovf, m_pend, m_act, m_saw;
  int m_age;  // cycles since the word was taken: 1 = low write, 2 = high write

  // Loader model: after the high write, idle for lb_delay cycles, busy lb_cnt cycles.
  int lb_delay = 0, lb_cnt = 0, cfg_n = 8, cfg_d = 0;
  bit rand_loader = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got nothing required an event (cycle %0d)", nm, cyc);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_lo = '0; m_last = '0; m_work = '0;
    m_lv = 0; m_ovf = 0; m_pend = 0; m_act = 0; m_saw = 0; m_age = 0;
    lb_delay = 0; lb_cnt = 0;
  endtask

  task automatic step(input bit rv, input bit wr, input logic [5:0] a,
                      input logic [31:0] d, input bit rr);
    bit e_wr, e_done, e_busy, full, lv_old, set_rl, take;
    logic [5:0] e_a;
    logic [31:0] e_d;
    @(negedge clk);
    rst_n      = rv;
    host_wr    = rv & wr;
    host_addr  = rv ? a : 6'h0;
    host_wdata = rv ? d : 32'h0;
    reload_req = rv & rr;
    if (!rv) m_reset();
    ld_busy = (lb_delay == 0) && (lb_cnt > 0);
    #1;
    e_wr   = m_act && (m_age == 1 || m_age == 2);
    e_a    = !e_wr ? 6'h0 : (m_age == 1 ? 6'h08 : 6'h0C);
    e_d    = !e_wr ? 32'h0 : (m_age == 1 ? m_work[31:0] : m_work[63:32]);
    e_done = m_act && m_saw && !ld_busy;
    e_busy = m_act || (m_q.size() != 0) || m_pend;
    chk("ld_write_req", ld_write_req, e_wr);
    chk("ld_address", ld_address, e_a);
    chk("ld_data", ld_data, e_d);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("fifo_level", fifo_level, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("last_valid", last_valid, m_lv);
    if (ld_write_req) wlog.push_back('{cyc, ld_address, ld_data});
    if (done) dlog.push_back(cyc);
    if (rv) begin
      full   = (m_q.size() >= DEPTH);
      lv_old = m_lv;
      set_rl = rr || (wr && a == 6'h10 && d[1]);
      take   = 0;
      if (m_act) begin
        if (e_done) begin
          m_last = m_work; m_lv = 1; m_act = 0;
        end else begin
          if (m_age >= 3 && ld_busy) m_saw = 1;
          m_age++;
        end
      end else if (m_q.size() > 0) begin
        m_work = m_q.pop_front();
        m_act = 1; m_age = 1; m_saw = 0;
      end else if (m_pend) begin
        m_work = m_last; m_pend = 0; take = 1;
        m_act = 1; m_age = 1; m_saw = 0;
      end
      if (!take && set_rl && lv_old) m_pend = 1;
      if (wr && a == 6'h08) m_lo = d;
      if (wr && a == 6'h0C) begin
        if (full) m_ovf = 1;
        else m_q.push_back({d, m_lo});
      end
      if (wr && a == 6'h10 && d[0]) m_ovf = 0;
    end
    if (rv && ld_write_req && ld_address == 6'h0C) begin
      lb_delay = rand_loader ? int'($urandom_range(0, 2)) : cfg_d;
      lb_cnt   = rand_loader ? int'($urandom_range(1, 8)) : cfg_n;
    end else if (lb_delay > 0) lb_delay--;
    else if (lb_cnt > 0) lb_cnt--;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 6'h0, 32'h0, 0);
  endtask

  task automatic push(input logic [31:0] lo, input logic [31:0] hi, input bit rr);
    step(1, 1, 6'h08, lo, 0);
    step(1, 1, 6'h0C, hi, rr);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_act || m_q.size() != 0 || m_pend) && k < 300) begin
      idle(1);
      k++;
    end
    if (k >= 300) note_fail("wait_idle_timeout");
    idle(1);
  endtask

  task automatic chk_wr(input string nm, input int c, input logic [5:0] a, input logic [31:0] d);
    bit found = 0;
    foreach (wlog[i]) begin
      if (wlog[i].cyc == c) begin
        found = 1;
        chk({nm, "_addr"}, wlog[i].a, a);
        chk({nm, "_data"}, wlog[i].d, d);
      end
    end
    if (!found) note_fail({nm, "_missing"});
  endtask

  initial begin
    int c0, d0, n, r;
    m_reset();
    step(0, 0, 6'h0, 32'h0, 0);
    step(0, 0, 6'h0, 32'h0, 0);
    chk("reset_busy_lit", busy, 0);
    chk("reset_level_lit", fifo_level, 0);

    // Reload with nothing committed is discarded.
    step(1, 0, 6'h0, 32'h0, 1);
    idle(3);
    chk("noreload_busy_lit", busy, 0);

    // First load: 0xC write is cycle c0.
    step(1, 1, 6'h08, 32'h11112222, 0);
    c0 = cyc;
    step(1, 1, 6'h0C, 32'h33334444, 0);
    wait_idle();
    chk_wr("first_lo", c0 + 2, 6'h08, 32'h11112222);
    chk_wr("first_hi", c0 + 3, 6'h0C, 32'h33334444);
    chk("first_done_count_lit", dlog.size(), 1);
    if (dlog.size() > 0) chk("first_done_cycle_lit", dlog[0], c0 + 12);
    chk("first_last_valid_lit", last_valid, 1);

    // Three pushes while the load sits in WAIT_DONE: third is dropped.
    d0 = dlog.size();
    push(32'hA0, 32'hA1, 0);
    idle(5);
    push(32'hB0, 32'hB1, 0);
    push(32'hC0, 32'hC1, 0);
    push(32'hD0, 32'hD1, 0);
    step(1, 1, 6'h10, 32'h1, 0);
    chk("ovf_set_lit", overflow, 1);
    idle(1);
    chk("ovf_clr_lit", overflow, 0);
    wait_idle();
    n = wlog.size();
    chk("ovf_done_count_lit", dlog.size() - d0, 3);
    if (n >= 6 && dlog.size() >= d0 + 3) begin
      chk("order_a_lit", wlog[n-5].d, 32'hA1);
      chk("order_b_lit", wlog[n-3].d, 32'hB1);
      chk("order_c_lit", wlog[n-1].d, 32'hC1);
      chk("gap_b_lit", wlog[n-4].cyc - dlog[d0], 2);
      chk("gap_c_lit", wlog[n-2].cyc - dlog[d0+1], 2);
    end

    // Commit a known word, then reload it.
    push(32'h0F0F0F0F, 32'hAAAA5555, 0);
    wait_idle();
    n = wlog.size();
    d0 = dlog.size();
    step(1, 0, 6'h0, 32'h0, 1);
    wait_idle();
    chk("reload_pairs_lit", wlog.size() - n, 2);
    chk("reload_done_lit", dlog.size() - d0, 1);
    if (wlog.size() >= n + 2) begin
      chk("reload_lo_lit", wlog[n].d, 32'h0F0F0F0F);
      chk("reload_hi_lit", wlog[n+1].d, 32'hAAAA5555);
    end

    // Reload together with a push: FIFO word first, extra pulses merge.
    n = wlog.size();
    d0 = dlog.size();
    push(32'h5A5A0001, 32'h5A5A0002, 1);
    idle(3);
    step(1, 0, 6'h0, 32'h0, 1);
    idle(1);
    step(1, 0, 6'h0, 32'h0, 1);
    wait_idle();
    chk("merge_done_lit", dlog.size() - d0, 2);
    chk("merge_pairs_lit", wlog.size() - n, 4);
    if (wlog.size() >= n + 4) chk("merge_reload_lo_lit", wlog[n+2].d, 32'h5A5A0001);

    // Push and pop on the same edge at level 1.
    step(1, 1, 6'h08, 32'h77, 0);
    step(1, 1, 6'h0C, 32'h78, 0);
    step(1, 1, 6'h0C, 32'h79, 0);
    idle(1);
    chk("pushpop_level_lit", fifo_level, 1);
    wait_idle();

    // Randomized traffic with a randomized loader and rare resets.
    rand_loader = 1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      step(1, 1, 6'h08, $urandom, 0);
      else if (r < 40) step(1, 1, 6'h0C, $urandom, $urandom_range(0, 9) == 0);
      else if (r < 44) step(1, 1, 6'h10, $urandom_range(0, 3), 0);
      else if (r < 50) step(1, 0, 6'h0, 32'h0, 1);
      else if (r < 52) step(1, 1, 6'($urandom_range(0, 63)) | 6'h01, $urandom, 0);
      else if (r < 53) step(0, 0, 6'h0, 32'h0, 0);
      else             idle(1);
    end
    rand_loader = 0;
    wait_idle();

    // Reset during WAIT_DONE abandons the load.
    push(32'h1, 32'h2, 0);
    wait_idle();
    push(32'h3, 32'h4, 0);
    idle(6);
    d0 = dlog.size();
    step(0, 0, 6'h0, 32'h0, 0);
    chk("rst_wr_lit", ld_write_req, 0);
    chk("rst_busy_lit", busy, 0);
    chk("rst_level_lit", fifo_level, 0);
    chk("rst_last_valid_lit", last_valid, 0);
    chk("rst_done_lit", done, 0);
    idle(15);
    chk("rst_no_done_lit", dlog.size() - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prism_cfg_sequencer.md
Name: prism_cfg_sequencer

Overview:
Sits between the RISC-V peripheral write bus and the 64-bit latch-chain loader. It buffers host 64-bit configuration words in a small FIFO, so the host never has to poll the loader. It replays each word into the loader as a low-half/high-half write pair and waits for the latch shift to complete. It also arbitrates a reload request that re-applies the last committed configuration.

Parameters:
FIFO_DEPTH, 2, number of buffered 64-bit config words; power of two, minimum 2.
LVL_W, 2, width of fifo_level; must hold values 0..FIFO_DEPTH.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
host_wr  in  1  one-cycle host write strobe
host_addr  in  6  host word address
host_wdata  in  32  host write data
reload_req  in  1  one-cycle external request to re-apply the last committed config
ld_write_req  out  1  write strobe to loader
ld_address  out  6  loader address (0x8 low half, 0xC high half and start)
ld_data  out  32  loader write data
ld_busy  in  1  loader busy
busy  out  1  sequencer not in IDLE, or FIFO non-empty, or reload pending
fifo_level  out  LVL_W  number of buffered entries
overflow  out  1  sticky: a push was dropped because the FIFO was full
last_valid  out  1  at least one config word has been committed since reset
done  out  1  one-cycle pulse when a load completes

Behaviour:
- Reset: reset is asynchronous, active-low (rst_n); clock is clk.
  - All state returns to IDLE.
  - FIFO is emptied; staging register, last_cfg, overflow, last_valid and reload-pending are cleared.
  - All outputs are 0.
  - A reset mid-sequence abandons the transfer; the loader shares rst_n.
- Host map, active on host_wr only:
  - 0x8: write host_wdata to lo_stage.
  - 0xC: push {host_wdata, lo_stage} into the FIFO.
  - 0x10: bit0=1 clears overflow; bit1=1 sets reload-pending.
  - Other addresses are ignored.
- Push when FIFO full: the entry is dropped, FIFO is unchanged, overflow is set on the next edge.
- Push and pop on the same edge are both honoured; fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- reload_req=1, or a write to 0x10 with bit1=1, sets reload-pending.
  - Repeated reload requests while pending merge into one.
  - A reload request while last_valid=0 is discarded.
- FSM states: IDLE, SEND_LO, SEND_HI, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If the FIFO is non-empty: pop the head into the working register and go to SEND_LO. The FIFO has priority over reload.
  - Else if reload-pending: copy last_cfg to the working register, clear reload-pending, go to SEND_LO.
- SEND_LO (1 cycle): ld_write_req=1, ld_address=0x8, ld_data=work[31:0]. Next state SEND_HI.
- SEND_HI (1 cycle): ld_write_req=1, ld_address=0xC, ld_data=work[63:32]. Next state WAIT_BUSY.
- WAIT_BUSY: wait for ld_busy=1, then go to WAIT_DONE. ld_busy must not be required in the SEND_HI cycle.
- WAIT_DONE: in the cycle where ld_busy=0:
  - done=1 (Mealy pulse);
  - last_cfg<=work, last_valid<=1;
  - next state IDLE.
- Outside SEND_LO/SEND_HI: ld_write_req=0, ld_address=0, ld_data=0.
- Back-to-back: with the FIFO non-empty at done, the next SEND_LO starts 2 cycles after the done cycle (WAIT_DONE→IDLE→SEND_LO). Loads never overlap.
- Host pushes during WAIT_* are accepted while FIFO space remains.
- The host writes only the sequencer; the loader sees only the ld_* ports.

Test Plan:
- Host writes 0x8=0x11112222, then 0xC=0x33334444 at cycle 0 → SEND_LO in cycle 2 (0x8/0x11112222), SEND_HI in cycle 3 (0xC/0x33334444). done pulses once when loader (NUM_REGS=8) busy drops; last_valid=1.
- Three pushes while the first load is in WAIT_DONE (depth 2) → two entries accepted, third dropped, overflow=1. A write to 0x10 with data 0x1 clears overflow. The two queued words load in order with exactly 2 idle cycles between loads.
- reload_req after reset with no commit → ignored, busy stays 0. After committing 0xAAAA5555_0F0F0F0F, reload_req → same pair reissued, done pulses.
- reload_req and a push in the same IDLE cycle → FIFO word loads first, reload follows. Two reload pulses during the first load → a single reload.
- Simultaneous push and pop at level 1 → level stays 1. Pointer wrap over 5 consecutive loads → data order preserved.
- rst_n low during WAIT_DONE → all outputs 0 immediately. FIFO empty, last_valid=0. No done pulse after release.
